// File: rtl/trig_gen_pkg.sv
// Shared types and timing constants for the trigger-sequence generator.
// The state enum covers the optional WAIT_SYNC state used with TRIG_GEN_EXT_SYNC_EN.
package trig_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOPPING  = 2'd2,
    WAIT_SYNC = 2'd3
  } trig_state_e;

  localparam int unsigned LEAD_DEF      = 4;
  localparam int unsigned DELTA_DLY_DEF = 8;

  // Shortest period that still fits PL1A, L1A and DELTA without overlap.
  function automatic int unsigned min_period(input int unsigned lead, input int unsigned dly);
    return lead + dly + 1;
  endfunction

  localparam int unsigned MIN_PERIOD = min_period(LEAD_DEF, DELTA_DLY_DEF);

endpackage

// File: rtl/trig_mod_cnt.sv
// Modulo-N event counter: hit is high while the count sits at zero.
// A divider of zero holds the counter and keeps hit low.
module trig_mod_cnt
  import trig_gen_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIV_W-1:0] div,
  output logic             hit
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + DIV_W'(1);
  assign hit     = (div != '0) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (adv && (div != '0)) begin
      cnt_q <= (cnt_inc == div) ? '0 : cnt_inc;
    end
  end

endmodule

// File: rtl/trig_pulse_gen.sv
// Programmable PL1A/L1A/PS/ALIGN/DELTA trigger-sequence generator, burst or continuous.
// Optional macro TRIG_GEN_EXT_SYNC_EN: each period waits for a synchronized ext_sync rising edge.
module trig_pulse_gen
  import trig_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LEAD      = LEAD_DEF,
  parameter int unsigned DELTA_DLY = DELTA_DLY_DEF,
  parameter int unsigned DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_ntrig,
  input  logic [DIV_W-1:0] cfg_ps_div,
  input  logic [DIV_W-1:0] cfg_align_div,
`ifdef TRIG_GEN_EXT_SYNC_EN
  input  logic             ext_sync,
`endif
  output logic             PL1A,
  output logic             L1A,
  output logic             PS,
  output logic             ALIGN,
  output logic             DELTA,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_sent
);

  localparam int unsigned      MIN_P    = min_period(LEAD, DELTA_DLY);
  localparam logic [CNT_W-1:0] MIN_P_W  = CNT_W'(MIN_P);
  localparam logic [CNT_W-1:0] PH_LEAD  = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] PH_DELTA = CNT_W'(LEAD + DELTA_DLY);

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] p_last_q;
  logic [CNT_W-1:0] ntrig_q;
  logic [DIV_W-1:0] ps_div_q;
  logic [DIV_W-1:0] align_div_q;
  logic             fin_q;

  logic             accept;
  logic             fin_d;
  logic             active;
  logic             at_end;
  logic             burst_done;
  logic             pl1a_d;
  logic             l1a_d;
  logic             delta_d;
  logic             ps_hit;
  logic             align_hit;

`ifdef TRIG_GEN_EXT_SYNC_EN
  logic [2:0] sync_q;
  logic       sync_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ext_sync};
    end
  end

  assign sync_edge = sync_q[1] & ~sync_q[2];

  localparam trig_state_e PERIOD_ENTRY = WAIT_SYNC;
`else
  localparam trig_state_e PERIOD_ENTRY = RUN;
`endif

  assign active     = (state_q == RUN) || (state_q == STOPPING);
  assign at_end     = active && (ph_q == p_last_q);
  assign burst_done = (ntrig_q != '0) && (cnt_sent == ntrig_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // Stop at the last phase ends immediately; otherwise the period is
  // finished in STOPPING so PL1A/L1A/DELTA always come out as a set.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    accept  = 1'b0;
    fin_d   = 1'b0;
    pl1a_d  = (state_q == RUN) && (ph_q == '0);
    l1a_d   = active && (ph_q == PH_LEAD);
    delta_d = active && (ph_q == PH_DELTA);
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          accept  = 1'b1;
          ph_d    = '0;
          state_d = PERIOD_ENTRY;
        end
      end
      RUN: begin
        if (at_end) begin
          ph_d = '0;
          if (burst_done || stop) begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end else begin
            state_d = PERIOD_ENTRY;
          end
        end else begin
          ph_d = ph_q + CNT_W'(1);
          if (stop) begin
            state_d = STOPPING;
          end
        end
      end
      STOPPING: begin
        if (at_end) begin
          ph_d    = '0;
          state_d = IDLE;
          fin_d   = 1'b1;
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
`ifdef TRIG_GEN_EXT_SYNC_EN
      WAIT_SYNC: begin
        ph_d = '0;
        if (stop) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else if (sync_edge) begin
          state_d = RUN;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_last_q    <= MIN_P_W - CNT_W'(1);
      ntrig_q     <= '0;
      ps_div_q    <= '0;
      align_div_q <= '0;
    end else if (accept) begin
      p_last_q    <= (cfg_period < MIN_P_W) ? (MIN_P_W - CNT_W'(1)) : (cfg_period - CNT_W'(1));
      ntrig_q     <= cfg_ntrig;
      ps_div_q    <= cfg_ps_div;
      align_div_q <= cfg_align_div;
    end
  end

  trig_mod_cnt #(.DIV_W(DIV_W)) u_ps_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .adv (l1a_d),
    .div (ps_div_q),
    .hit (ps_hit)
  );

  trig_mod_cnt #(.DIV_W(DIV_W)) u_align_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .adv (l1a_d),
    .div (align_div_q),
    .hit (align_hit)
  );

  // fin_q adds the stage that lets done rise together with busy falling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PL1A     <= 1'b0;
      L1A      <= 1'b0;
      PS       <= 1'b0;
      ALIGN    <= 1'b0;
      DELTA    <= 1'b0;
      busy     <= 1'b0;
      fin_q    <= 1'b0;
      done     <= 1'b0;
      cnt_sent <= '0;
    end else begin
      PL1A  <= pl1a_d;
      L1A   <= l1a_d;
      PS    <= l1a_d & ps_hit;
      ALIGN <= l1a_d & align_hit;
      DELTA <= delta_d;
      busy  <= (state_q != IDLE);
      fin_q <= fin_d;
      done  <= fin_q;
      if (accept) begin
        cnt_sent <= '0;
      end else if (l1a_d && (cnt_sent != '1)) begin
        cnt_sent <= cnt_sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Scoreboard bench for trig_pulse_gen: expected pulse events are queued at start
// and a monitor compares every cycle in which the DUT raises a pulse or done.
module tb_trig_pulse_gen;

  localparam int unsigned T_LEAD = 4;
  localparam int unsigned T_DLY  = 8;
  localparam int unsigned T_MINP = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [31:0] cfg_ntrig = '0;
  logic [15:0] cfg_ps_div = '0;
  logic [15:0] cfg_align_div = '0;
`ifdef TRIG_GEN_EXT_SYNC_EN
  logic        ext_sync = 1'b0;
`endif
  logic        PL1A, L1A, PS, ALIGN, DELTA, busy, done;
  logic [31:0] cnt_sent;

  trig_pulse_gen #(.CNT_W(32), .LEAD(4), .DELTA_DLY(8), .DIV_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .cfg_period    (cfg_period),
    .cfg_ntrig     (cfg_ntrig),
    .cfg_ps_div    (cfg_ps_div),
    .cfg_align_div (cfg_align_div),
`ifdef TRIG_GEN_EXT_SYNC_EN
    .ext_sync      (ext_sync),
`endif
    .PL1A          (PL1A),
    .L1A           (L1A),
    .PS            (PS),
    .ALIGN         (ALIGN),
    .DELTA         (DELTA),
    .busy          (busy),
    .done          (done),
    .cnt_sent      (cnt_sent)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags: {PL1A, L1A, PS, ALIGN, DELTA, done}
  typedef struct {
    int unsigned cyc;
    logic [5:0]  flags;
    logic        busy;
    logic [31:0] cnt;
  } ev_t;

  ev_t  expq[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  ev_t  mon_e;
  logic [5:0] mon_got;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_got = {PL1A, L1A, PS, ALIGN, DELTA, done};
      if (mon_got != 6'b0) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, mon_got);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.cyc != cyc || mon_e.flags != mon_got || mon_e.busy != busy || mon_e.cnt != cnt_sent) begin
            bad++;
            $display("FAIL event cyc=%0d flags=%b busy=%b cnt=%0d required cyc=%0d flags=%b busy=%b cnt=%0d",
                     cyc, mon_got, busy, cnt_sent, mon_e.cyc, mon_e.flags, mon_e.busy, mon_e.cnt);
          end
        end
      end else if (expq.size() != 0 && expq[0].cyc < cyc) begin
        mon_e = expq.pop_front();
        total++;
        bad++;
        $display("FAIL missing_event cyc=%0d got=none required cyc=%0d flags=%b", cyc, mon_e.cyc, mon_e.flags);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push(input int unsigned c, input logic [5:0] f, input logic b, input int unsigned n);
    ev_t e;
    e.cyc = c; e.flags = f; e.busy = b; e.cnt = n;
    expq.push_back(e);
  endtask

  // Reference: sequence accepted at edge s produces n whole periods of length P;
  // a stop seen at edge s+off ends the sequence after the period containing it.
  task automatic push_seq(input int unsigned s, input int unsigned per, input int unsigned ntrig,
                          input int unsigned psd, input int unsigned ald, input int unsigned stop_off);
    int unsigned p, ks, n, base;
    logic ps, al;
    p  = (per < T_MINP) ? T_MINP : per;
    ks = (stop_off == 0) ? 32'hFFFF_FFFF : (stop_off - 1) / p + 1;
    n  = (ntrig == 0 || ks < ntrig) ? ks : ntrig;
    for (int unsigned k = 0; k < n; k++) begin
      base = s + 1 + k * p;
      ps = (psd != 0) && (k % psd == 0);
      al = (ald != 0) && (k % ald == 0);
      push(base, 6'b100000, 1'b1, k);
      push(base + T_LEAD, {1'b0, 1'b1, ps, al, 2'b00}, 1'b1, k + 1);
      push(base + T_LEAD + T_DLY, 6'b000010, 1'b1, k + 1);
    end
    push(s + n * p + 1, 6'b000001, 1'b0, n);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (expq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_seq(input int unsigned per, input int unsigned ntrig, input int unsigned psd,
                         input int unsigned ald, input int unsigned stop_off, input bit poke);
    int unsigned s;
    @(negedge clk);
    start = 1'b1;
    cfg_period = per; cfg_ntrig = ntrig;
    cfg_ps_div = 16'(psd); cfg_align_div = 16'(ald);
    s = cyc + 1;
    push_seq(s, per, ntrig, psd, ald, stop_off);
    @(negedge clk);
    start = 1'b0;
    cfg_period = $urandom_range(1, 40); cfg_ntrig = $urandom_range(0, 5);
    cfg_ps_div = 16'($urandom_range(0, 4)); cfg_align_div = 16'($urandom_range(0, 4));
    if (poke && (stop_off == 0 || stop_off >= 4)) begin
      @(negedge clk);
      start = 1'b1;
      cfg_period = 5; cfg_ntrig = 1; cfg_ps_div = 16'd1; cfg_align_div = 16'd0;
      @(negedge clk);
      start = 1'b0;
    end
    if (stop_off != 0) begin
      while (cyc + 1 < s + stop_off) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned per, nt, psd, ald, so, p;
    int unsigned s;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pulses", {58'b0, PL1A, L1A, PS, ALIGN, DELTA, done}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_cnt", {32'b0, cnt_sent}, 64'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(20, 3, 2, 3, 0, 1'b0);
    check("cnt_after_burst", {32'b0, cnt_sent}, 64'd3);
    run_seq(5, 2, 0, 0, 0, 1'b0);
    run_seq(20, 0, 1, 2, 23, 1'b0);
    check("cnt_after_stop", {32'b0, cnt_sent}, 64'd2);

    @(negedge clk);
    start = 1'b1; stop = 1'b1; cfg_period = 20; cfg_ntrig = 1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (20) @(negedge clk);
    check("start_stop_idle_busy", {63'b0, busy}, 64'd0);
    check("cnt_held_idle", {32'b0, cnt_sent}, 64'd2);

    run_seq(20, 3, 0, 1, 0, 1'b1);

    // asynchronous reset in the middle of a burst
    @(negedge clk);
    start = 1'b1; cfg_period = 20; cfg_ntrig = 3; cfg_ps_div = 16'd2; cfg_align_div = 16'd3;
    s = cyc + 1;
    push_seq(s, 20, 3, 2, 3, 0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("async_reset_outputs", {25'b0, PL1A, L1A, PS, ALIGN, DELTA, busy, done, cnt_sent}, 64'd0);
    expq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    run_seq(20, 2, 2, 3, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      per = $urandom_range(1, 30);
      nt  = $urandom_range(0, 4);
      psd = $urandom_range(0, 3);
      ald = $urandom_range(0, 3);
      p   = (per < T_MINP) ? T_MINP : per;
      so  = 0;
      if (nt == 0) so = $urandom_range(1, 4 * p);
      else if ($urandom_range(0, 1) == 1) so = $urandom_range(1, nt * p + 3);
      run_seq(per, nt, psd, ald, so, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
